ov7670_frame_ctrl: RTL and testbench
====================================

# ov7670_frame_ctrl

Frame-level capture sequencer between `ov7670_capture` and a two-bank camera frame buffer. It aligns capture writes to OV7670 VSYNC frame boundaries and supports stop, continuous and single-snapshot modes. It ping-pongs the two buffer banks so the OLED/processing reader always sees a complete, stable frame, and counts good and dropped frames. The block runs entirely in the capture clock domain; VSYNC is resynchronised internally.

## Interface
Parameters:
- `c_img_pxls`, 4800, pixels per frame (80x60).
- `c_nb_img_pxls`, 13, bank address width.
- `c_nb_buf`, 12, pixel word width (RGB444).
- `c_nb_cnt`, 8, width of `frame_cnt` and `drop_cnt`.

Ports:
- `clk` in 1: capture clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vsync` in 1: raw camera VSYNC; high during vertical blanking.
- `mode` in 2: 00 stop, 01 continuous, 10 snapshot, 11 treated as stop.
- `snap_req` in 1: one-cycle pulse, arms a snapshot in mode 10.
- `cap_we` in 1: write strobe from the capture block.
- `cap_addr` in `c_nb_img_pxls`: pixel address from the capture block.
- `cap_data` in `c_nb_buf`: pixel data from the capture block.
- `cons_ack` in 1: one-cycle pulse, reader has finished with `rd_bank`.
- `fb_we` out 1: frame buffer write enable.
- `fb_waddr` out `c_nb_img_pxls+1`: {`wr_bank`, `cap_addr`}.
- `fb_wdata` out `c_nb_buf`: registered `cap_data`.
- `rd_bank` out 1: bank holding the last complete frame; always equals ~`wr_bank`.
- `frame_valid` out 1: `rd_bank` holds an unconsumed complete frame.
- `busy` out 1: state is not IDLE.
- `bad_frame` out 1: one-cycle pulse when a frame is discarded for a wrong pixel count.
- `frame_cnt` out `c_nb_cnt`: count of good frames published; wraps.
- `drop_cnt` out `c_nb_cnt`: count of good frames not published because the reader was busy; saturates at all-ones.

## Operation
- VSYNC passes through a two-flop synchroniser and one edge-detect flop, giving `vs_rise` and `vs_fall` pulses.
- State machine:
  - IDLE: leave when `mode`=01, or when `mode`=10 and `snap_req`=1. Go to WAIT_VS.
  - WAIT_VS: wait for the next `vs_rise` (frame boundary). Go to ARMED. Never start mid-frame.
  - ARMED: on `vs_fall`, clear the pixel counter and go to CAPTURE.
  - CAPTURE: `fb_we` = `cap_we` gated; every gated write increments `pix_cnt` (width `c_nb_img_pxls+1`). Once `pix_cnt`=`c_img_pxls`, further writes are suppressed and the `long` flag is set. On `vs_rise`, go to FRAME_END.
  - FRAME_END (one cycle): a frame is good iff `pix_cnt`=`c_img_pxls` and `long`=0.
    - Good and `frame_valid`=0: toggle `wr_bank`, set `frame_valid`, increment `frame_cnt`.
    - Good and `frame_valid`=1: increment `drop_cnt`; the writer overwrites its own bank next frame.
    - Bad: pulse `bad_frame`, no swap.
    - Next state:
      - Snapshot, good frame published: IDLE.
      - Snapshot, frame not published: ARMED (retry).
      - Continuous: ARMED (already on a boundary).
      - `mode`=00 or 11: IDLE.
- `mode` is sampled only in IDLE and FRAME_END. The exception is `mode`=00/11 during WAIT_VS, ARMED or CAPTURE, which aborts to IDLE on the next cycle: `fb_we` deasserts immediately, no swap, counters unchanged.
- `cons_ack` clears `frame_valid` in any state. If `cons_ack` and a publishing FRAME_END coincide, the ack is applied first, so `frame_valid` stays 1 for the new bank.
- `cons_ack` with `frame_valid`=0 is ignored.

## Timing
- Reset values:
  - `fb_we`=0, `fb_waddr`=0, `fb_wdata`=0.
  - `wr_bank`=0, `rd_bank`=1.
  - `frame_valid`=0, `busy`=0, `bad_frame`=0.
  - `frame_cnt`=0, `drop_cnt`=0.
  - State IDLE.
- Write path latency is exactly 1 clk: `cap_we`/`cap_addr`/`cap_data` at edge N appear on `fb_*` at edge N+1. The `wr_bank` bit is sampled at the same edge.
- `vsync` pin to `vs_rise`/`vs_fall` is 3 clk. A publishing frame updates `rd_bank`/`frame_valid`/`frame_cnt` 1 clk after `vs_rise` (FRAME_END registered).
- Bank swap never occurs while `fb_we` can be asserted for the old bank. The write strobe issued in the last CAPTURE cycle still uses the old bank.
- Asserting `rst_n` low mid-frame clears everything asynchronously; no partial frame is ever published.

## Test plan
- Continuous mode, three frames of exactly 4800 writes, `cons_ack` after each: `frame_cnt`=3, `rd_bank` toggles 1→0→1, `fb_waddr[13]` alternates 0,1,0.
- Snapshot: `mode`=10 plus `snap_req` asserted mid-frame. The partial frame is ignored, the next full frame is published, the FSM returns to IDLE, and `frame_valid`=1, `busy`=0.
- Continuous mode with no `cons_ack`: frame 1 is published; frames 2–4 give `drop_cnt`=3 while `rd_bank` stays 1. Force `drop_cnt` near 255 and check that it saturates.
- Short frame (4799 writes) and long frame (4801 writes): each gives one `bad_frame` pulse and no swap; the 4801st write never reaches `fb_we`.
- `mode`→00 at pixel 2000: `fb_we`=0 from the next cycle, state IDLE, `rd_bank`/`frame_cnt` unchanged.
- `cons_ack` coincident with the publishing FRAME_END: `frame_valid` stays 1, `rd_bank` switches to the new bank, `drop_cnt` is unchanged.

Source files
------------

// File: rtl/ov7670_frame_ctrl.sv
// Frame-level capture sequencer: aligns OV7670 capture writes to VSYNC frame
// boundaries and ping-pongs two frame-buffer banks so the reader always owns
// a complete, stable frame.  Single capture-clock domain; VSYNC resynchronised.
module ov7670_frame_ctrl #(
  parameter int c_img_pxls    = 4800,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 12,
  parameter int c_nb_cnt      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vsync,
  input  logic [1:0]               mode,
  input  logic                     snap_req,
  input  logic                     cap_we,
  input  logic [c_nb_img_pxls-1:0] cap_addr,
  input  logic [c_nb_buf-1:0]      cap_data,
  input  logic                     cons_ack,
  output logic                     fb_we,
  output logic [c_nb_img_pxls:0]   fb_waddr,
  output logic [c_nb_buf-1:0]      fb_wdata,
  output logic                     rd_bank,
  output logic                     frame_valid,
  output logic                     busy,
  output logic                     bad_frame,
  output logic [c_nb_cnt-1:0]      frame_cnt,
  output logic [c_nb_cnt-1:0]      drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_VS   = 3'd1,
    S_ARMED     = 3'd2,
    S_CAPTURE   = 3'd3,
    S_FRAME_END = 3'd4
  } state_t;

  localparam logic [c_nb_img_pxls:0] c_full    = (c_nb_img_pxls+1)'(c_img_pxls);
  localparam logic [c_nb_img_pxls:0] c_pix_one = (c_nb_img_pxls+1)'(1);
  localparam logic [c_nb_cnt-1:0]    c_cnt_one = c_nb_cnt'(1);

  state_t                   state_reg, state_next;
  logic                     vs_meta_reg, vs_sync_reg, vs_dly_reg;
  logic                     vs_rise, vs_fall;
  logic [c_nb_img_pxls:0]   pix_cnt_reg;
  logic                     long_reg;
  logic                     fb_we_reg;
  logic [c_nb_img_pxls:0]   fb_waddr_reg;
  logic [c_nb_buf-1:0]      fb_wdata_reg;
  logic                     wr_bank_reg;
  logic                     frame_valid_reg;
  logic                     bad_frame_reg;
  logic [c_nb_cnt-1:0]      frame_cnt_reg;
  logic [c_nb_cnt-1:0]      drop_cnt_reg;

  logic mode_cont, mode_snap, mode_stop;
  logic frame_full, frame_good, valid_after_ack;
  logic in_capture, in_frame_end;
  logic wr_gate, long_hit, publish, drop;

  // Mode decode; the reserved code 11 behaves like stop.
  assign mode_cont = (mode == 2'b01);
  assign mode_snap = (mode == 2'b10);
  assign mode_stop = ~(mode_cont | mode_snap);

  // Two-flop synchroniser plus edge-detect flop on the raw VSYNC pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta_reg <= 1'b0;
      vs_sync_reg <= 1'b0;
      vs_dly_reg  <= 1'b0;
    end else begin
      vs_meta_reg <= vsync;
      vs_sync_reg <= vs_meta_reg;
      vs_dly_reg  <= vs_sync_reg;
    end
  end

  assign vs_rise = vs_sync_reg & ~vs_dly_reg;
  assign vs_fall = ~vs_sync_reg & vs_dly_reg;

  assign in_capture   = (state_reg == S_CAPTURE);
  assign in_frame_end = (state_reg == S_FRAME_END);
  assign frame_full   = (pix_cnt_reg == c_full);
  assign frame_good   = frame_full & ~long_reg;

  // A stop request gates the strobe in the same cycle so fb_we drops at once.
  assign wr_gate  = in_capture & cap_we & ~mode_stop & ~frame_full;
  assign long_hit = in_capture & cap_we & ~mode_stop & frame_full;

  // A coincident acknowledge frees the read bank before the publish decision.
  assign valid_after_ack = frame_valid_reg & ~cons_ack;
  assign publish         = in_frame_end & frame_good & ~valid_after_ack;
  assign drop            = in_frame_end & frame_good & valid_after_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; mode is only honoured in IDLE/FRAME_END, except stop aborts.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (mode_cont || (mode_snap && snap_req)) state_next = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (mode_stop)    state_next = S_IDLE;
        else if (vs_rise) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (mode_stop)    state_next = S_IDLE;
        else if (vs_fall) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (mode_stop)    state_next = S_IDLE;
        else if (vs_rise) state_next = S_FRAME_END;
      end
      S_FRAME_END: begin
        if (mode_cont)      state_next = S_ARMED;
        else if (mode_snap) state_next = publish ? S_IDLE : S_ARMED;
        else                state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pixel counter and overrun flag, cleared at the start of every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_reg <= '0;
      long_reg    <= 1'b0;
    end else if ((state_reg == S_ARMED) && vs_fall) begin
      pix_cnt_reg <= '0;
      long_reg    <= 1'b0;
    end else begin
      if (wr_gate)  pix_cnt_reg <= pix_cnt_reg + c_pix_one;
      if (long_hit) long_reg    <= 1'b1;
    end
  end

  // One-cycle registered write path; the bank bit is sampled with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we_reg    <= 1'b0;
      fb_waddr_reg <= '0;
      fb_wdata_reg <= '0;
    end else begin
      fb_we_reg    <= wr_gate;
      fb_waddr_reg <= {wr_bank_reg, cap_addr};
      fb_wdata_reg <= cap_data;
    end
  end

  // Bank ownership, frame handshake and statistics, resolved in FRAME_END.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_reg     <= 1'b0;
      frame_valid_reg <= 1'b0;
      bad_frame_reg   <= 1'b0;
      frame_cnt_reg   <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      bad_frame_reg <= in_frame_end & ~frame_good;
      if (publish) begin
        wr_bank_reg     <= ~wr_bank_reg;
        frame_valid_reg <= 1'b1;
        frame_cnt_reg   <= frame_cnt_reg + c_cnt_one;
      end else if (cons_ack) begin
        frame_valid_reg <= 1'b0;
      end
      if (drop && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + c_cnt_one;
    end
  end

  assign fb_we       = fb_we_reg;
  assign fb_waddr    = fb_waddr_reg;
  assign fb_wdata    = fb_wdata_reg;
  assign rd_bank     = ~wr_bank_reg;
  assign frame_valid = frame_valid_reg;
  assign busy        = (state_reg != S_IDLE);
  assign bad_frame   = bad_frame_reg;
  assign frame_cnt   = frame_cnt_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Self-checking bench for ov7670_frame_ctrl: randomised pixel streams checked
// against a frame-level reference model (bank ownership, counters, bad frames).
module tb_ov7670_frame_ctrl;

  localparam int PX = 4800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [1:0]  mode;
  logic        snap_req;
  logic        cap_we;
  logic [12:0] cap_addr;
  logic [11:0] cap_data;
  logic        cons_ack;
  logic        fb_we;
  logic [13:0] fb_waddr;
  logic [11:0] fb_wdata;
  logic        rd_bank, frame_valid, busy, bad_frame;
  logic [7:0]  frame_cnt, drop_cnt;

  // small instance used only to reach drop-counter saturation quickly
  logic        s_fb_we;
  logic [3:0]  s_fb_waddr;
  logic [11:0] s_fb_wdata;
  logic        s_rd_bank, s_frame_valid, s_busy, s_bad_frame;
  logic [2:0]  s_frame_cnt, s_drop_cnt;

  always #5 clk = ~clk;

  ov7670_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .mode(mode), .snap_req(snap_req),
    .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data), .cons_ack(cons_ack),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .rd_bank(rd_bank),
    .frame_valid(frame_valid), .busy(busy), .bad_frame(bad_frame),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  ov7670_frame_ctrl #(.c_img_pxls(4), .c_nb_img_pxls(3), .c_nb_buf(12), .c_nb_cnt(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .mode(mode), .snap_req(snap_req),
    .cap_we(cap_we), .cap_addr(cap_addr[2:0]), .cap_data(cap_data), .cons_ack(cons_ack),
    .fb_we(s_fb_we), .fb_waddr(s_fb_waddr), .fb_wdata(s_fb_wdata), .rd_bank(s_rd_bank),
    .frame_valid(s_frame_valid), .busy(s_busy), .bad_frame(s_bad_frame),
    .frame_cnt(s_frame_cnt), .drop_cnt(s_drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the main instance (frame-level view)
  bit m_wr;
  bit m_valid;
  int m_fcnt;
  int m_drop;
  int m_bad;

  // write-stream monitor statistics
  int          we_cnt = 0;
  int          we_bank_bad = 0;
  int          we_data_bad = 0;
  int          bad_cnt = 0;
  logic [12:0] drv_addr_q;
  logic [11:0] drv_data_q;

  always @(posedge clk) begin
    drv_addr_q <= cap_addr;
    drv_data_q <= cap_data;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) begin
        we_cnt++;
        if (fb_waddr[13] !== m_wr) we_bank_bad++;
        if (fb_waddr[12:0] !== drv_addr_q || fb_wdata !== drv_data_q) we_data_bad++;
      end
      if (bad_frame) bad_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr = 1'b0; m_valid = 1'b0; m_fcnt = 0; m_drop = 0; m_bad = 0;
    bad_cnt = 0;
  endtask

  // Blanking interval; optionally acks in the FRAME_END cycle (3 clk after the pin rises).
  task automatic vs_pulse(input bit ack_coinc);
    tick(); vsync = 1'b1;
    tick(); tick(); tick();
    if (ack_coinc) cons_ack = 1'b1;
    tick(); cons_ack = 1'b0;
    repeat (4) tick();
    vsync = 1'b0;
    repeat (6) tick();
  endtask

  task automatic write_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        cap_we = 1'b0;
        tick();
      end
      cap_we   = 1'b1;
      cap_addr = 13'(i);
      cap_data = 12'($urandom);
      tick();
    end
    cap_we = 1'b0;
  endtask

  task automatic do_ack();
    cons_ack = 1'b1;
    tick();
    cons_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic start_mode(input logic [1:0] m);
    mode = m;
    repeat (2) tick();
    vs_pulse(1'b0);
  endtask

  task automatic stop();
    mode = 2'b00;
    repeat (3) tick();
  endtask

  // One captured frame of n writes, then the frame-level model update.
  task automatic run_frame(input int n, input bit ack_coinc);
    int exp_we;
    we_cnt = 0; we_bank_bad = 0; we_data_bad = 0;
    write_pixels(n);
    vs_pulse(ack_coinc);
    exp_we = (n > PX) ? PX : n;
    n_cmp++;
    if (we_cnt !== exp_we) begin
      n_err++; $display("FAIL frame_we_count: got %0d required %0d (n=%0d)", we_cnt, exp_we, n);
    end
    n_cmp++;
    if (we_bank_bad !== 0 || we_data_bad !== 0) begin
      n_err++; $display("FAIL frame_write_path: bank_errs %0d data_errs %0d required 0/0", we_bank_bad, we_data_bad);
    end
    if (ack_coinc) m_valid = 1'b0;
    if (n == PX) begin
      if (!m_valid) begin m_wr = ~m_wr; m_valid = 1'b1; m_fcnt++; end
      else if (m_drop < 255) m_drop++;
    end else begin
      m_bad++;
    end
    $display("frame n=%0d ack=%0b: rd_bank=%0b valid=%0b frame_cnt=%0d drop_cnt=%0d bad=%0d",
             n, ack_coinc, rd_bank, frame_valid, frame_cnt, drop_cnt, bad_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b0; mode = 2'b00; snap_req = 1'b0;
    cap_we = 1'b0; cap_addr = '0; cap_data = '0; cons_ack = 1'b0;
    model_reset();
    repeat (3) tick();
    n_cmp++;
    if (fb_we !== 1'b0 || fb_waddr !== 14'd0 || fb_wdata !== 12'd0) begin
      n_err++; $display("FAIL reset_write_port: we=%0b addr=%0h data=%0h required 0/0/0", fb_we, fb_waddr, fb_wdata);
    end
    n_cmp++;
    if (rd_bank !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0 || bad_frame !== 1'b0) begin
      n_err++; $display("FAIL reset_status: rd=%0b valid=%0b busy=%0b bad=%0b required 1/0/0/0", rd_bank, frame_valid, busy, bad_frame);
    end
    n_cmp++;
    if (frame_cnt !== 8'd0 || drop_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_counters: frame_cnt=%0d drop_cnt=%0d required 0/0", frame_cnt, drop_cnt);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_stop: busy=%0b required 0", busy);
    end
    $display("reset: rd_bank=%0b valid=%0b busy=%0b", rd_bank, frame_valid, busy);
  endtask

  task automatic test_continuous();
    start_mode(2'b01);
    for (int k = 0; k < 3; k++) begin
      run_frame(PX, 1'b0);
      n_cmp++;
      if (rd_bank !== ~m_wr || frame_valid !== m_valid || frame_cnt !== 8'(m_fcnt)) begin
        n_err++; $display("FAIL continuous_publish: rd=%0b valid=%0b cnt=%0d required %0b/%0b/%0d",
                          rd_bank, frame_valid, frame_cnt, ~m_wr, m_valid, m_fcnt);
      end
      do_ack();
    end
    n_cmp++;
    if (frame_cnt !== 8'd3 || rd_bank !== 1'b0) begin
      n_err++; $display("FAIL continuous_final: cnt=%0d rd=%0b required 3/0", frame_cnt, rd_bank);
    end
    stop();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL continuous_stop: busy=%0b required 0", busy);
    end
  endtask

  task automatic test_snapshot();
    we_cnt = 0;
    write_pixels(1000);
    mode = 2'b10; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL snapshot_armed: busy=%0b required 1", busy);
    end
    write_pixels(1000);
    n_cmp++;
    if (we_cnt !== 0) begin
      n_err++; $display("FAIL snapshot_partial_ignored: writes=%0d required 0", we_cnt);
    end
    vs_pulse(1'b0);
    run_frame(PX, 1'b0);
    n_cmp++;
    if (frame_valid !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'(m_fcnt) || rd_bank !== ~m_wr) begin
      n_err++; $display("FAIL snapshot_publish: valid=%0b busy=%0b cnt=%0d rd=%0b required 1/0/%0d/%0b",
                        frame_valid, busy, frame_cnt, rd_bank, m_fcnt, ~m_wr);
    end
    stop();
  endtask

  task automatic test_drop();
    logic rd_hold;
    do_ack();
    start_mode(2'b01);
    run_frame(PX, 1'b0);
    rd_hold = rd_bank;
    for (int k = 0; k < 3; k++) begin
      run_frame(PX, 1'b0);
      n_cmp++;
      if (rd_bank !== rd_hold || drop_cnt !== 8'(m_drop) || frame_valid !== 1'b1) begin
        n_err++; $display("FAIL drop_frame: rd=%0b drop=%0d valid=%0b required %0b/%0d/1",
                          rd_bank, drop_cnt, frame_valid, rd_hold, m_drop);
      end
    end
    n_cmp++;
    if (drop_cnt !== 8'd3) begin
      n_err++; $display("FAIL drop_total: drop=%0d required 3", drop_cnt);
    end
    stop();
  endtask

  task automatic test_short_long();
    logic rd_hold;
    logic [7:0] cnt_hold;
    do_ack();
    rd_hold = rd_bank; cnt_hold = frame_cnt;
    start_mode(2'b01);
    run_frame(PX - 1, 1'b0);
    n_cmp++;
    if (bad_cnt !== m_bad || rd_bank !== rd_hold || frame_cnt !== cnt_hold || frame_valid !== 1'b0) begin
      n_err++; $display("FAIL short_frame: bad=%0d rd=%0b cnt=%0d valid=%0b required %0d/%0b/%0d/0",
                        bad_cnt, rd_bank, frame_cnt, frame_valid, m_bad, rd_hold, cnt_hold);
    end
    run_frame(PX + 1, 1'b0);
    n_cmp++;
    if (bad_cnt !== m_bad || rd_bank !== rd_hold || frame_cnt !== cnt_hold || frame_valid !== 1'b0) begin
      n_err++; $display("FAIL long_frame: bad=%0d rd=%0b cnt=%0d valid=%0b required %0d/%0b/%0d/0",
                        bad_cnt, rd_bank, frame_cnt, frame_valid, m_bad, rd_hold, cnt_hold);
    end
    stop();
  endtask

  task automatic test_abort();
    logic rd_hold;
    logic [7:0] cnt_hold;
    rd_hold = rd_bank; cnt_hold = frame_cnt;
    start_mode(2'b01);
    we_cnt = 0;
    write_pixels(2000);
    mode = 2'b00;
    cap_we = 1'b1; cap_addr = 13'd2000; cap_data = 12'($urandom);
    tick();
    cap_we = 1'b0;
    n_cmp++;
    if (fb_we !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_immediate: fb_we=%0b busy=%0b required 0/0", fb_we, busy);
    end
    vs_pulse(1'b0);
    n_cmp++;
    if (we_cnt !== 2000 || rd_bank !== rd_hold || frame_cnt !== cnt_hold || bad_cnt !== m_bad) begin
      n_err++; $display("FAIL abort_state: writes=%0d rd=%0b cnt=%0d bad=%0d required 2000/%0b/%0d/%0d",
                        we_cnt, rd_bank, frame_cnt, bad_cnt, rd_hold, cnt_hold, m_bad);
    end
    $display("abort: writes=%0d rd_bank=%0b frame_cnt=%0d", we_cnt, rd_bank, frame_cnt);
  endtask

  task automatic test_back_to_back();
    logic [7:0] drop_hold;
    start_mode(2'b01);
    run_frame(PX, 1'b0);
    drop_hold = drop_cnt;
    run_frame(PX, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b1 || rd_bank !== ~m_wr || drop_cnt !== drop_hold || frame_cnt !== 8'(m_fcnt)) begin
      n_err++; $display("FAIL ack_coincident: valid=%0b rd=%0b drop=%0d cnt=%0d required 1/%0b/%0d/%0d",
                        frame_valid, rd_bank, drop_cnt, frame_cnt, ~m_wr, drop_hold, m_fcnt);
    end
    stop();
  endtask

  task automatic test_random();
    int n;
    int a;
    start_mode(2'b01);
    for (int k = 0; k < 2; k++) begin
      n = PX - 1 + int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 2));
      if (a == 1) do_ack();
      run_frame(n, a == 2);
      n_cmp++;
      if (rd_bank !== ~m_wr || frame_valid !== m_valid || frame_cnt !== 8'(m_fcnt) ||
          drop_cnt !== 8'(m_drop) || bad_cnt !== m_bad) begin
        n_err++; $display("FAIL random_frame: rd=%0b valid=%0b cnt=%0d drop=%0d bad=%0d required %0b/%0b/%0d/%0d/%0d",
                          rd_bank, frame_valid, frame_cnt, drop_cnt, bad_cnt, ~m_wr, m_valid, m_fcnt, m_drop, m_bad);
      end
    end
    stop();
  endtask

  task automatic test_reset_midframe();
    do_ack();
    start_mode(2'b01);
    write_pixels(500);
    cap_we = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fb_we !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0 || frame_cnt !== 8'd0 ||
        drop_cnt !== 8'd0 || rd_bank !== 1'b1) begin
      n_err++; $display("FAIL reset_midframe: we=%0b busy=%0b valid=%0b cnt=%0d drop=%0d rd=%0b required 0/0/0/0/0/1",
                        fb_we, busy, frame_valid, frame_cnt, drop_cnt, rd_bank);
    end
    cap_we = 1'b0;
    mode = 2'b00;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("reset mid-frame: rd_bank=%0b valid=%0b frame_cnt=%0d", rd_bank, frame_valid, frame_cnt);
  endtask

  task automatic test_saturation();
    bit s_valid = 1'b0;
    int s_fcnt = 0;
    int s_drop = 0;
    start_mode(2'b01);
    for (int k = 0; k < 10; k++) begin
      write_pixels(4);
      vs_pulse(1'b0);
      if (!s_valid) begin s_valid = 1'b1; s_fcnt++; end
      else if (s_drop < 7) s_drop++;
      n_cmp++;
      if (s_drop_cnt !== 3'(s_drop) || s_frame_cnt !== 3'(s_fcnt)) begin
        n_err++; $display("FAIL drop_saturation: drop=%0d cnt=%0d required %0d/%0d", s_drop_cnt, s_frame_cnt, s_drop, s_fcnt);
      end
      $display("sat frame %0d: drop_cnt=%0d frame_cnt=%0d", k, s_drop_cnt, s_frame_cnt);
    end
    stop();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_snapshot();
    test_drop();
    test_short_long();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
